// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed seven-segment display driver. A packed multi-digit value
// and its per-digit decimal points are captured into shadow registers on
// `load`. A prescaler divides the clock into digit slots of SCAN_DIV cycles.
// Each clock, the registered outputs show the digit selected by the current
// scan index: one-hot enable, decoded segments (hex or dash for 10..15, with
// optional leading-zero blanking) and the decimal point. `frame` pulses for
// one cycle when the displayed digit wraps from the last digit back to 0.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   load      capture value/dp_in into the shadow registers at the edge
//   value     packed nibbles, nibble i = value[4i+3:4i], digit 0 is the LSD
//   dp_in     per-digit decimal point, captured with value
//   hex_mode  1: nibbles 10..15 shown as hex letters, 0: shown as dash
//   blank_lz  blank leading zero digits (digit 0 is never blanked)
//   seg       active-high segments, seg[0]=a .. seg[6]=g
//   dp        active-high decimal point of the displayed digit
//   an        one-hot active-high digit enable
//   frame     one-cycle pulse when the display wraps to digit 0
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]   sdp_q, sdp_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q, frame_d;
    logic                wrap_q, wrap_d;

    logic                slot_end;
    logic [3:0]          nib;
    logic                blank;
    logic                zero_from;

    function automatic logic [6:0] decode(input logic [3:0] n, input logic hex);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h67;
            4'hA: s = hex ? 7'h77 : 7'h40;
            4'hB: s = hex ? 7'h7C : 7'h40;
            4'hC: s = hex ? 7'h39 : 7'h40;
            4'hD: s = hex ? 7'h5E : 7'h40;
            4'hE: s = hex ? 7'h79 : 7'h40;
            default: s = hex ? 7'h71 : 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        shadow_d  = load ? value : shadow_q;
        sdp_d     = load ? dp_in : sdp_q;

        slot_end  = (pre_q == PRE_LAST);
        pre_d     = slot_end ? '0 : pre_q + PW'(1);
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        // wrap_q marks that idx just returned to 0; the display follows one
        // cycle later, so frame is the delayed wrap.
        wrap_d    = slot_end && (idx_q == IDX_LAST);
        frame_d   = wrap_q;

        nib       = 4'h0;
        dp_d      = 1'b0;
        blank     = 1'b0;
        an_d      = '0;
        zero_from = 1'b1;
        // Walk from the most significant digit down so zero_from tells
        // whether this nibble and everything above it is zero.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_from = zero_from && (shadow_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                nib     = shadow_q[4*i +: 4];
                dp_d    = sdp_q[i];
                an_d[i] = 1'b1;
                blank   = blank_lz && (i != 0) && zero_from;
            end
        end
        seg_d = blank ? 7'h00 : decode(nib, hex_mode);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            sdp_q    <= '0;
            pre_q    <= '0;
            idx_q    <= '0;
            seg_q    <= '0;
            dp_q     <= 1'b0;
            an_q     <= '0;
            frame_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            sdp_q    <= sdp_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
            wrap_q   <= wrap_d;
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule
